synth_param_bank: RTL

Parametrised bank of user-adjustable synth settings (amplitude, attack, decay, sustain, release, and any further slots) driven by increment/decrement keys from the PS/2 front end. It replaces ad-hoc per-setting registers with one selectable, saturating register file. It adds edge-detected stepping with optional hold-to-repeat, and feeds the ALU controller and HEX display logic.

---
 rtl/synth_param_pkg.sv | 20 ++
 rtl/synth_param_bank_key_repeat.sv | 94 +++++++++
 rtl/synth_param_bank.sv | 129 ++++++++++++
 3 files changed

// File: rtl/synth_param_pkg.sv
// Shared constants for the synth parameter bank: slot indices,
// repeat FSM states and default step/saturation settings.
package synth_param_pkg;

    localparam int P_AMP     = 0;
    localparam int P_ATTACK  = 1;
    localparam int P_DECAY   = 2;
    localparam int P_SUSTAIN = 3;
    localparam int P_RELEASE = 4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HOLD,
        ST_REPEAT
    } rep_st_t;

    localparam int          STEP_SHIFT_DEF = 23;
    localparam int unsigned MAX_VAL_DEF    = 32'd1073741824;

endpackage

// File: rtl/synth_param_bank_key_repeat.sv
// Key edge detect plus hold-to-repeat FSM; emits step_up/step_dn pulses.
// Only built when SYNTH_PARAM_REPEAT_EN is defined.
`ifdef SYNTH_PARAM_REPEAT_EN
module key_repeat
    import synth_param_pkg::*;
#(
    parameter int          SW     = 3,
    parameter int unsigned DELAY  = 8,
    parameter int unsigned PERIOD = 4
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_inc,
    input  logic          i_dec,
    input  logic [SW-1:0] i_sel,
    output logic          o_step_up,
    output logic          o_step_dn
);

    localparam int unsigned LMAX = (DELAY > PERIOD) ? DELAY : PERIOD;
    localparam int          CW   = $clog2(LMAX) + 1;
    localparam logic [CW-1:0] LD_DELAY  = CW'(DELAY - 1);
    localparam logic [CW-1:0] LD_PERIOD = CW'(PERIOD - 1);

    rep_st_t       r_state, w_state_n;
    logic [CW-1:0] r_cnt, w_cnt_n;
    logic          r_up, w_up_n;
    logic          r_inc_q, r_dec_q;
    logic [SW-1:0] r_sel_q;

    logic w_dir_up, w_dir_dn;
    logic w_rise_up, w_rise_dn;
    logic w_drop;

    assign w_dir_up  = i_inc & ~i_dec;
    assign w_dir_dn  = i_dec & ~i_inc;
    assign w_rise_up = w_dir_up & ~r_inc_q;
    assign w_rise_dn = w_dir_dn & ~r_dec_q;
    // Held direction lost, both keys down, or target slot moved
    assign w_drop = (r_up ? ~w_dir_up : ~w_dir_dn) | (i_sel != r_sel_q);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_up    <= 1'b0;
            r_inc_q <= 1'b0;
            r_dec_q <= 1'b0;
            r_sel_q <= '0;
        end else begin
            r_state <= w_state_n;
            r_cnt   <= w_cnt_n;
            r_up    <= w_up_n;
            r_inc_q <= i_inc;
            r_dec_q <= i_dec;
            r_sel_q <= i_sel;
        end
    end

    always_comb begin
        w_state_n = r_state;
        w_cnt_n   = r_cnt;
        w_up_n    = r_up;
        o_step_up = 1'b0;
        o_step_dn = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (w_rise_up || w_rise_dn) begin
                    o_step_up = w_rise_up;
                    o_step_dn = w_rise_dn;
                    w_up_n    = w_rise_up;
                    w_cnt_n   = LD_DELAY;
                    w_state_n = ST_HOLD;
                end
            end
            ST_HOLD, ST_REPEAT: begin
                if (w_drop) begin
                    w_state_n = ST_IDLE;
                    w_cnt_n   = '0;
                end else if (r_cnt == '0) begin
                    o_step_up = r_up;
                    o_step_dn = ~r_up;
                    w_cnt_n   = LD_PERIOD;
                    w_state_n = ST_REPEAT;
                end else begin
                    w_cnt_n = r_cnt - 1'b1;
                end
            end
            default: w_state_n = ST_IDLE;
        endcase
    end

endmodule
`endif

// File: rtl/synth_param_bank.sv
// Saturating, selectable synth parameter register file with key stepping.
// SYNTH_PARAM_REPEAT_EN enables hold-to-repeat via key_repeat.
module synth_param_bank
    import synth_param_pkg::*;
#(
    parameter int                  NUM_PARAMS    = 5,
    parameter int                  WIDTH         = 31,
    parameter int                  STEP_SHIFT    = STEP_SHIFT_DEF,
    parameter int unsigned         MAX_VAL       = MAX_VAL_DEF,
    parameter logic [NUM_PARAMS-1:0] ZERO_MASK   = 5'b00100,
    parameter int unsigned         REPEAT_DELAY  = 25000000,
    parameter int unsigned         REPEAT_PERIOD = 5000000
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          inc,
    input  logic                          dec,
    input  logic [$clog2(NUM_PARAMS)-1:0] sel,
    output logic [NUM_PARAMS*WIDTH-1:0]   params,
    output logic [3:0]                    sel_nibble,
    output logic                          upd,
    output logic [$clog2(NUM_PARAMS)-1:0] upd_idx,
    output logic [NUM_PARAMS-1:0]         sat
);

    localparam int SW = $clog2(NUM_PARAMS);
    localparam int W1 = WIDTH + 1;
    localparam logic [WIDTH-1:0] MAX_W = WIDTH'(MAX_VAL);
    localparam logic [WIDTH:0]   MAX_E = W1'(MAX_VAL);
    localparam logic [WIDTH:0]   STP_E = W1'(1) << STEP_SHIFT;

    logic w_up, w_dn;

`ifdef SYNTH_PARAM_REPEAT_EN
    key_repeat #(
        .SW     (SW),
        .DELAY  (REPEAT_DELAY),
        .PERIOD (REPEAT_PERIOD)
    ) u_key_repeat (
        .i_clk     (clk),
        .i_rst_n   (reset),
        .i_inc     (inc),
        .i_dec     (dec),
        .i_sel     (sel),
        .o_step_up (w_up),
        .o_step_dn (w_dn)
    );
`else
    logic r_inc_q, r_dec_q;
    logic w_unused_cfg;

    assign w_unused_cfg = ^{REPEAT_DELAY[0], REPEAT_PERIOD[0]};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_inc_q <= 1'b0;
            r_dec_q <= 1'b0;
        end else begin
            r_inc_q <= inc;
            r_dec_q <= dec;
        end
    end

    assign w_up = inc & ~dec & ~r_inc_q;
    assign w_dn = dec & ~inc & ~r_dec_q;
`endif

    logic [WIDTH-1:0]      r_val [NUM_PARAMS];
    logic [WIDTH-1:0]      w_nxt [NUM_PARAMS];
    logic [NUM_PARAMS-1:0] r_sat;
    logic                  r_upd;
    logic [SW-1:0]         r_idx;
    logic                  w_hit;
    logic [3:0]            w_nib;

    // Extra headroom bit keeps the bound compares free of wrap-around
    function automatic logic [WIDTH-1:0] f_step(
        input logic [WIDTH-1:0] v,
        input logic             up
    );
        logic [WIDTH:0] x;
        x = {1'b0, v};
        if (up) x = (x > MAX_E - STP_E) ? MAX_E : x + STP_E;
        else    x = (x < STP_E) ? '0 : x - STP_E;
        return x[WIDTH-1:0];
    endfunction

    assign w_hit = (w_up | w_dn) & ({1'b0, sel} < W1'(NUM_PARAMS));

    always_comb begin
        for (int i = 0; i < NUM_PARAMS; i++) begin
            w_nxt[i] = r_val[i];
            if (w_hit && sel == SW'(i)) w_nxt[i] = f_step(r_val[i], w_up);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_PARAMS; i++)
                r_val[i] <= ZERO_MASK[i] ? '0 : MAX_W;
            r_sat <= '1;
            r_upd <= 1'b0;
            r_idx <= '0;
        end else begin
            for (int i = 0; i < NUM_PARAMS; i++) begin
                r_val[i] <= w_nxt[i];
                r_sat[i] <= (w_nxt[i] == '0) || (w_nxt[i] == MAX_W);
            end
            r_upd <= w_hit;
            if (w_hit) r_idx <= sel;
        end
    end

    always_comb begin
        w_nib = '0;
        for (int i = 0; i < NUM_PARAMS; i++)
            if (sel == SW'(i)) w_nib = r_val[i][WIDTH-1 -: 4];
    end

    for (genvar g = 0; g < NUM_PARAMS; g++) begin : g_bus
        assign params[g*WIDTH +: WIDTH] = r_val[g];
    end

    assign sel_nibble = w_nib;
    assign upd        = r_upd;
    assign upd_idx    = r_idx;
    assign sat        = r_sat;

endmodule
